fib_index_finder: RTL

//   Inverse of the Fibonacci generator chip. Takes an unsigned value and reports

---
 rtl/fib_index_finder.sv | 96 +++++++++
 1 files changed

// File: rtl/fib_index_finder.sv
// Classifies an unsigned value as Fibonacci or not by walking the sequence one
// term per clock; reports the matching index or the index of the largest smaller term.
module fib_index_finder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDX_W-1:0] index
);

    localparam int AW = WIDTH + 2;
    localparam int KW = IDX_W + 1;
    localparam logic [AW-1:0] TERM_ONE = AW'(1);
    localparam logic [KW-1:0] STEP_ONE = KW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] v;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [KW-1:0] k;
    logic [KW-1:0] k_dec;

    assign k_dec = k - STEP_ONE;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEARCH;
            SEARCH:  if (a >= v) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, e.g. b <= a + b reads the old a.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            v      <= '0;
            a      <= '0;
            b      <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            is_fib <= 1'b0;
            index  <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SEARCH);
            done  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        v      <= {2'b00, value};
                        a      <= '0;
                        b      <= TERM_ONE;
                        k      <= '0;
                        is_fib <= 1'b0;
                        index  <= '0;
                    end
                end
                SEARCH: begin
                    if (a == v) begin
                        is_fib <= 1'b1;
                        index  <= k[IDX_W-1:0];
                    end else if (a > v) begin
                        // a starts at 0, so a > v never happens at k=0 and k-1 cannot underflow.
                        is_fib <= 1'b0;
                        index  <= k_dec[IDX_W-1:0];
                    end else begin
                        a <= b;
                        b <= a + b;
                        k <= k + STEP_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
